// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate sequential multiplier.
// Holds the state encoding, the column-mask function and the counter width.
package approx_mult_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiplicand bits kept for row j: bit i survives when i + j >= cut.
  function automatic logic [MAX_W-1:0] col_mask(input int j, input int cut, input logic approx);
    if (!approx || cut <= j)
      return {MAX_W{1'b1}};
    else
      return {MAX_W{1'b1}} << (cut - j);
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// Operand/result handshake bundle for approx_mult_seq.
interface approx_mult_seq_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x_in;
  logic [WIDTH-1:0]   y_in;
  logic               approx_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p_out;
  logic               busy;

  modport master (
    output in_valid, x_in, y_in, approx_in, out_ready,
    input  in_ready, out_valid, p_out, busy
  );

  modport slave (
    input  in_valid, x_in, y_in, approx_in, out_ready,
    output in_ready, out_valid, p_out, busy
  );
endinterface

// File: rtl/approx_pp_row.sv
// Combinational partial-product row: masked multiplicand shifted to column j,
// or zero when the multiplier bit is clear.
module approx_pp_row
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CUT   = WIDTH - 1
) (
  input  logic [WIDTH-1:0]              x,
  input  logic                          y_bit,
  input  logic [cnt_width(WIDTH)-1:0]   j,
  input  logic                          approx,
  output logic [2*WIDTH-1:0]            row
);

  logic [WIDTH-1:0] mask;

  assign mask = WIDTH'(col_mask(32'(j), CUT, approx));
  assign row  = y_bit ? ({{WIDTH{1'b0}}, x & mask} << j) : '0;

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential shift-add multiplier, one partial-product row per clock,
// with optional truncation of all columns below CUT.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CUT   = WIDTH - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  approx_mult_seq_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < 2 || WIDTH > MAX_W || CUT < 0 || CUT > 2*WIDTH-1) begin : g_bad_param
    $fatal(1, "approx_mult_seq: illegal WIDTH/CUT combination");
  end

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     x_r;
  logic [WIDTH-1:0]     y_sh;
  logic                 mode_r;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   row;
  logic                 last_row;

  // y is consumed LSB-first from a shift register, so y_sh[0] is always y_j.
  approx_pp_row #(.WIDTH(WIDTH), .CUT(CUT)) u_row (
    .x      (x_r),
    .y_bit  (y_sh[0]),
    .j      (cnt),
    .approx (mode_r),
    .row    (row)
  );

  assign last_row = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_row) state_nx = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x_r    <= '0;
      y_sh   <= '0;
      mode_r <= 1'b0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r    <= bus.x_in;
            y_sh   <= bus.y_in;
            mode_r <= bus.approx_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc  <= acc + row;
          y_sh <= y_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.p_out = acc;

endmodule
